l2_neuron_layer: RTL
====================

L2_NEURON_LAYER -- requirements
Module: l2_neuron_layer

Interface
REQ-001 SHALL: parameter P_WIDTH, default 8, weight width; trace width is P_WIDTH+1; potential width is 2*P_WIDTH+4.
REQ-002 SHALL: parameter P_TICK, default 16, clocks per trace-decay step.
REQ-003 SHALL: parameter P_REFRAC, default 32, refractory length in clocks (used only with the refractory feature).
REQ-004 SHALL: i_clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL: i_event  in  6  L1 spike pulses, bit k means input k (1..6).
REQ-007 SHALL: i_weights  in  3*6*P_WIDTH  neuron n, input k weight at slice [((n-1)*6+(k-1))*P_WIDTH +: P_WIDTH].
REQ-008 SHALL: i_thresholds  in  3*(2*P_WIDTH+4)  neuron n threshold at slice n-1.
REQ-009 SHALL: o_spikeout  out  3  one-hot winner pulse, one clock wide.
REQ-010 SHALL: o_ts  out  6*(P_WIDTH+1)  trace snapshot used by the current or last evaluation, input k at slice k-1.
REQ-011 SHALL: o_lv  out  3*(2*P_WIDTH+4)  per-neuron potential from the last evaluation.
REQ-012 SHALL: o_busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL: each input keeps a trace; when i_event[k] is sampled high, trace k loads 2^P_WIDTH (256).
REQ-014 SHALL: a free-running prescaler pulses every P_TICK clocks; on each pulse, every nonzero trace decrements by 1 and saturates at 0; an event load takes priority over a decay on the same edge.
REQ-015 SHALL: the FSM has four states, IDLE, ACC, CMP and FIRE.
REQ-016 SHALL: in IDLE, when any i_event bit is high at edge E0, the FSM enters ACC, snapshots all six traces (values after the E0 load) into o_ts, and clears the three accumulators.
REQ-017 SHALL: in ACC, edges E1..E6 add w[n][k]*snap[k] for k=1..6 to accumulator n (unsigned, full width), and E6 moves the FSM to CMP; no overflow is possible at 2*P_WIDTH+4 bits.
REQ-018 SHALL: at E7 (CMP->FIRE), o_lv loads all three accumulators, and o_spikeout asserts the one-hot winner or 3'b000 if there is no candidate.
REQ-019 SHALL: a neuron is a candidate when acc >= threshold and acc != 0; the winner is the largest acc, and ties go to the lowest index.
REQ-020 SHALL: at E8, o_spikeout clears; FIRE goes to ACC (with a new snapshot) if the pending flag is set, otherwise to IDLE.
REQ-021 SHALL: an event sampled in ACC, CMP or FIRE updates the traces and sets the pending flag; the flag clears on entry to ACC; multiple events collapse into one pending evaluation.
REQ-022 SHALL: simultaneous events on several inputs produce a single evaluation.
REQ-023 SHALL: o_ts and o_lv stay stable from their load until the next load, so o_ts is valid on the o_spikeout rising edge.
REQ-024 SHALL: weights and thresholds are sampled combinationally during ACC/CMP; changes outside those states have no effect until the next evaluation.

Reset
REQ-025 SHALL: on i_rst_n low, asynchronously, the FSM goes to IDLE and the following clear to 0: traces, prescaler, pending flag, accumulators, refractory counters, o_spikeout, o_ts, o_lv and o_busy.
REQ-026 SHALL: reset asserted mid-evaluation aborts the evaluation with no spike; the first event after release starts a fresh evaluation.

Configuration
REQ-027 SHALL: with macro L2_REFRACTORY_EN defined, a neuron that fires is excluded from candidacy for P_REFRAC clocks counted from E7, and its accumulator and o_lv are still computed.
REQ-028 SHALL: without L2_REFRACTORY_EN, no inhibition logic exists and every neuron is eligible in every evaluation.

Verification
REQ-029 SHALL: all weights 0x7F, thresholds 0x06000, event on input 1 -> o_spikeout=3'b001 seven clocks after the event edge, each o_lv=0x07F00, o_ts slice 0=256.
REQ-030 SHALL: neuron 2 weights 0xFF, others 0x7F, thresholds 0x06000, event on input 1 -> o_spikeout=3'b010, neuron 2 o_lv=0x0FF00.
REQ-031 SHALL: all thresholds 0x0FFFF, weights 0x7F, event on input 1 -> o_spikeout stays 3'b000, o_lv=0x07F00 each, o_busy low after E8.
REQ-032 SHALL: event on input 3, then 160 idle clocks, then event on input 4 -> o_ts input-3 slice=246, input-4 slice=256.
REQ-033 SHALL: second event sampled during ACC -> FIRE moves directly to ACC, two spikes 8 clocks apart, and a third event in the same window adds no extra evaluation.
REQ-034 SHALL: with L2_REFRACTORY_EN, the REQ-029 stimulus repeated 10 clocks later -> second spike 3'b010 (neuron 1 inhibited); without the macro -> second spike 3'b001.

Source files
------------

// File: rtl/l2_neuron_layer.sv
// rtl/l2_neuron_layer.sv - three-neuron winner-take-all layer over six decaying input traces
// Optional refractory inhibition of the last winner is built when L2_REFRACTORY_EN is defined.
module l2_neuron_layer #(
    parameter int P_WIDTH  = 8,
    parameter int P_TICK   = 16,
    parameter int P_REFRAC = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [5:0]                     i_event,
    input  logic [3*6*P_WIDTH-1:0]         i_weights,
    input  logic [3*(2*P_WIDTH+4)-1:0]     i_thresholds,
    output logic [2:0]                     o_spikeout,
    output logic [6*(P_WIDTH+1)-1:0]       o_ts,
    output logic [3*(2*P_WIDTH+4)-1:0]     o_lv,
    output logic                           o_busy
);

    localparam int LP_TW = P_WIDTH + 1;
    localparam int LP_AW = 2 * P_WIDTH + 4;
    localparam int LP_PW = (P_TICK > 1) ? $clog2(P_TICK) : 1;
    localparam logic [LP_TW-1:0] LP_TRACE_MAX = {1'b1, {P_WIDTH{1'b0}}};
    localparam logic [LP_PW-1:0] LP_PRE_LAST  = LP_PW'(P_TICK - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CMP, S_FIRE} state_t;

    state_t             state_q;
    logic [LP_PW-1:0]   pre_q;
    logic               tick;
    logic               any_event;
    logic [LP_TW-1:0]   trace_q [6];
    logic [LP_TW-1:0]   trace_d [6];
    logic [LP_TW-1:0]   snap_q  [6];
    logic [LP_AW-1:0]   acc_q   [3];
    logic [LP_AW-1:0]   lv_q    [3];
    logic [LP_AW-1:0]   term    [3];
    logic [2:0]         idx_q;
    logic               pend_q;
    logic [2:0]         eligible;
    logic [2:0]         winner;
    logic [LP_AW-1:0]   best;
    logic [LP_TW-1:0]   sel_trace;
    logic [P_WIDTH-1:0] sel_w;

    assign any_event = |i_event;
    assign tick      = (pre_q == LP_PRE_LAST);

    // An event load wins over a decay landing on the same edge.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            if (i_event[k]) begin
                trace_d[k] = LP_TRACE_MAX;
            end else if (tick && (trace_q[k] != '0)) begin
                trace_d[k] = trace_q[k] - 1'b1;
            end else begin
                trace_d[k] = trace_q[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= '0;
            for (int k = 0; k < 6; k++) begin
                trace_q[k] <= '0;
            end
        end else begin
            pre_q   <= tick ? '0 : pre_q + 1'b1;
            trace_q <= trace_d;
        end
    end

    // One input per ACC cycle: idx_q selects the snapshot trace and each neuron's weight.
    always_comb begin
        sel_trace = '0;
        sel_w     = '0;
        for (int k = 0; k < 6; k++) begin
            if (idx_q == 3'(k)) begin
                sel_trace = snap_q[k];
            end
        end
        for (int n = 0; n < 3; n++) begin
            sel_w = '0;
            for (int k = 0; k < 6; k++) begin
                if (idx_q == 3'(k)) begin
                    sel_w = i_weights[(n*6+k)*P_WIDTH +: P_WIDTH];
                end
            end
            term[n] = LP_AW'(sel_w) * LP_AW'(sel_trace);
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best   = '0;
        winner = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (eligible[n] && (acc_q[n] != '0) &&
                (acc_q[n] >= i_thresholds[n*LP_AW +: LP_AW]) &&
                ((winner == 3'b000) || (acc_q[n] > best))) begin
                best   = acc_q[n];
                winner = 3'(1 << n);
            end
        end
    end

`ifdef L2_REFRACTORY_EN
    localparam int LP_RW = $clog2(P_REFRAC + 1);
    logic [LP_RW-1:0] refrac_q [3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < 3; n++) begin
                refrac_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if ((state_q == S_CMP) && winner[n]) begin
                    refrac_q[n] <= LP_RW'(P_REFRAC);
                end else if (refrac_q[n] != '0) begin
                    refrac_q[n] <= refrac_q[n] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            eligible[n] = (refrac_q[n] == '0);
        end
    end
`else
    assign eligible = 3'b111;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            o_busy     <= 1'b0;
            o_spikeout <= 3'b000;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            for (int k = 0; k < 6; k++) begin
                snap_q[k] <= '0;
            end
            for (int n = 0; n < 3; n++) begin
                acc_q[n] <= '0;
                lv_q[n]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_event) begin
                        state_q <= S_ACC;
                        o_busy  <= 1'b1;
                        pend_q  <= 1'b0;
                        idx_q   <= '0;
                        snap_q  <= trace_d;
                        for (int n = 0; n < 3; n++) begin
                            acc_q[n] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    for (int n = 0; n < 3; n++) begin
                        acc_q[n] <= acc_q[n] + term[n];
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == 3'd5) begin
                        state_q <= S_CMP;
                    end
                    if (any_event) begin
                        pend_q <= 1'b1;
                    end
                end
                S_CMP: begin
                    state_q    <= S_FIRE;
                    o_spikeout <= winner;
                    for (int n = 0; n < 3; n++) begin
                        lv_q[n] <= acc_q[n];
                    end
                    if (any_event) begin
                        pend_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    o_spikeout <= 3'b000;
                    // An event arriving on this very edge folds into the re-run too.
                    if (pend_q || any_event) begin
                        state_q <= S_ACC;
                        pend_q  <= 1'b0;
                        idx_q   <= '0;
                        snap_q  <= trace_d;
                        for (int n = 0; n < 3; n++) begin
                            acc_q[n] <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            o_ts[k*LP_TW +: LP_TW] = snap_q[k];
        end
        for (int n = 0; n < 3; n++) begin
            o_lv[n*LP_AW +: LP_AW] = lv_q[n];
        end
    end

endmodule
